// File: rtl/ysyx_22050550_ifu_fetch_pkg.sv
// rtl/ysyx_22050550_ifu_fetch_pkg.sv - fetch FSM state encoding, NOP constant and word-select helper
package ysyx_22050550_ifu_fetch_pkg;

    typedef enum logic [1:0] {
        IFU_IDLE = 2'd0,
        IFU_REQ  = 2'd1,
        IFU_WAIT = 2'd2,
        IFU_HOLD = 2'd3
    } ifu_state_t;

    localparam logic [31:0] IFU_NOP_INST = 32'h0000_0013;

    // A 64-bit memory beat carries two instructions; addr[2] chooses the upper one.
    function automatic logic [31:0] pick_word(input logic [63:0] data, input logic upper);
        return upper ? data[63:32] : data[31:0];
    endfunction

endpackage

// File: rtl/ysyx_22050550_ifu_fetch_if.sv
// rtl/ysyx_22050550_ifu_fetch_if.sv - instruction memory bus and IF/ID handshake bundle
interface ysyx_22050550_ifu_fetch_if #(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 64
);
    logic              imem_req_valid;
    logic [ADDR_W-1:0] imem_req_addr;
    logic              imem_req_ready;
    logic              imem_rsp_valid;
    logic [DATA_W-1:0] imem_rsp_data;
    logic              imem_rsp_err;
    logic              if_valid;
    logic [ADDR_W-1:0] if_pc;
    logic [31:0]       if_inst;
    logic              if_err;
    logic              id_ready;

    modport master (
        output imem_req_valid, imem_req_addr, if_valid, if_pc, if_inst, if_err,
        input  imem_req_ready, imem_rsp_valid, imem_rsp_data, imem_rsp_err, id_ready
    );

    modport slave (
        input  imem_req_valid, imem_req_addr, if_valid, if_pc, if_inst, if_err,
        output imem_req_ready, imem_rsp_valid, imem_rsp_data, imem_rsp_err, id_ready
    );
endinterface

// File: rtl/ysyx_22050550_ifu_perf.sv
// rtl/ysyx_22050550_ifu_perf.sv - three saturating 64-bit event counters for the fetch unit
module ysyx_22050550_ifu_perf (
    input  logic        clock,
    input  logic        reset,
    input  logic        fetch_inc,
    input  logic        stall_inc,
    input  logic        kill_inc,
    output logic [63:0] fetch_cnt,
    output logic [63:0] stall_cnt,
    output logic [63:0] kill_cnt
);
    always_ff @(posedge clock) begin
        if (reset) begin
            fetch_cnt <= '0;
            stall_cnt <= '0;
            kill_cnt  <= '0;
        end else begin
            if (fetch_inc && fetch_cnt != '1) fetch_cnt <= fetch_cnt + 64'd1;
            if (stall_inc && stall_cnt != '1) stall_cnt <= stall_cnt + 64'd1;
            if (kill_inc  && kill_cnt  != '1) kill_cnt  <= kill_cnt  + 64'd1;
        end
    end
endmodule

// File: rtl/ysyx_22050550_ifu_fetch.sv
// rtl/ysyx_22050550_ifu_fetch.sv - single-outstanding instruction fetch FSM with flush;
// perf counters added when YSYX_22050550_IFU_PERF_EN is defined
module ysyx_22050550_ifu_fetch
    import ysyx_22050550_ifu_fetch_pkg::*;
#(
    parameter int          ADDR_W   = 64,
    parameter int          DATA_W   = 64,
    parameter logic [31:0] NOP_INST = IFU_NOP_INST
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [ADDR_W-1:0] pc_i,
    input  logic              flush_i,
    output logic              ready_o,
    ysyx_22050550_ifu_fetch_if.master bus
`ifdef YSYX_22050550_IFU_PERF_EN
    ,
    output logic [63:0]       perf_fetch_o,
    output logic [63:0]       perf_stall_o,
    output logic [63:0]       perf_kill_o
`endif
);
    localparam logic [ADDR_W-1:0] LINE_MASK = ~ADDR_W'(DATA_W / 8 - 1);

    ifu_state_t        state_q, state_d;
    logic              kill_q, kill_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       inst_q, inst_d;
    logic              err_q, err_d;
    logic [63:0]       rsp_wide;

    assign rsp_wide = 64'(bus.imem_rsp_data);

    always_comb begin
        state_d = state_q;
        kill_d  = kill_q;
        addr_d  = addr_q;
        inst_d  = inst_q;
        err_d   = err_q;
        case (state_q)
            IFU_IDLE: begin
                addr_d = pc_i;
                // Misaligned PCs never reach the bus; ID sees a faulting NOP instead.
                if (pc_i[1:0] != 2'b00) begin
                    state_d = IFU_HOLD;
                    err_d   = 1'b1;
                    inst_d  = NOP_INST;
                end else begin
                    state_d = IFU_REQ;
                end
            end
            IFU_REQ: begin
                if (flush_i) kill_d = 1'b1;
                if (bus.imem_req_ready) state_d = IFU_WAIT;
            end
            IFU_WAIT: begin
                if (bus.imem_rsp_valid) begin
                    if (kill_q || flush_i) begin
                        kill_d  = 1'b0;
                        state_d = IFU_IDLE;
                    end else begin
                        state_d = IFU_HOLD;
                        inst_d  = pick_word(rsp_wide, (DATA_W == 64) && addr_q[2]);
                        err_d   = bus.imem_rsp_err;
                    end
                end else if (flush_i) begin
                    kill_d = 1'b1;
                end
            end
            IFU_HOLD: begin
                if (flush_i || bus.id_ready) state_d = IFU_IDLE;
            end
            default: state_d = IFU_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IFU_IDLE;
            kill_q  <= 1'b0;
            addr_q  <= '0;
            inst_q  <= NOP_INST;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            kill_q  <= kill_d;
            addr_q  <= addr_d;
            inst_q  <= inst_d;
            err_q   <= err_d;
        end
    end

    assign bus.imem_req_valid = (state_q == IFU_REQ);
    assign bus.imem_req_addr  = addr_q & LINE_MASK;
    assign bus.if_valid       = (state_q == IFU_HOLD);
    assign bus.if_pc          = addr_q;
    assign bus.if_inst        = inst_q;
    assign bus.if_err         = err_q;
    assign ready_o            = (state_q == IFU_HOLD) && bus.id_ready && !flush_i;

`ifdef YSYX_22050550_IFU_PERF_EN
    logic kill_evt;
    assign kill_evt = ((state_q == IFU_WAIT) && bus.imem_rsp_valid && (kill_q || flush_i))
                    || ((state_q == IFU_HOLD) && flush_i);

    ysyx_22050550_ifu_perf u_perf (
        .clock     (clock),
        .reset     (reset),
        .fetch_inc (ready_o),
        .stall_inc ((state_q == IFU_REQ) || (state_q == IFU_WAIT)),
        .kill_inc  (kill_evt),
        .fetch_cnt (perf_fetch_o),
        .stall_cnt (perf_stall_o),
        .kill_cnt  (perf_kill_o)
    );
`endif
endmodule

// File: tb/tb_ysyx_22050550_ifu_fetch.sv
// tb/tb_ysyx_22050550_ifu_fetch.sv - directed and randomized checks of the fetch unit against a transaction-level model
module tb_ysyx_22050550_ifu_fetch;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst;
    logic [63:0] pc;
    logic        flush;
    logic        ready;

    always #5 clk = ~clk;

    ysyx_22050550_ifu_fetch_if #(.ADDR_W(64), .DATA_W(64)) bus ();

`ifdef YSYX_22050550_IFU_PERF_EN
    logic [63:0] perf_fetch, perf_stall, perf_kill;
`endif

    ysyx_22050550_ifu_fetch #(.ADDR_W(64), .DATA_W(64)) dut (
        .clock   (clk),
        .reset   (rst),
        .pc_i    (pc),
        .flush_i (flush),
        .ready_o (ready),
        .bus     (bus)
`ifdef YSYX_22050550_IFU_PERF_EN
        ,
        .perf_fetch_o (perf_fetch),
        .perf_stall_o (perf_stall),
        .perf_kill_o  (perf_kill)
`endif
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    // Memory image: one fixed line for the directed tests, an address hash elsewhere.
    function automatic logic [63:0] mem_line(input logic [63:0] a);
        if (a == 64'h8000_0000) return 64'h00100093_00000013;
        return {a[31:0] ^ 32'hdead_beef, a[31:0] + 32'h1234_5678};
    endfunction

    function automatic logic mem_fault(input logic [63:0] a);
        return a[11:8] == 4'hE;
    endfunction

    function automatic logic [31:0] exp_inst(input logic [63:0] p);
        logic [63:0] line;
        if (p[1:0] != 2'b00) return NOP;
        line = mem_line({p[63:3], 3'b000});
        return p[2] ? line[63:32] : line[31:0];
    endfunction

    function automatic logic exp_err(input logic [63:0] p);
        return (p[1:0] != 2'b00) || mem_fault({p[63:3], 3'b000});
    endfunction

    bit          rand_mode = 0;
    int          rsp_delay = 0;
    int          stall_left = 0;
    bit          outstanding = 0;
    logic [63:0] mem_addr;
    int          mem_cnt;
    int          hs_count = 0;

    bit          s_rst = 1, s_valid, s_hs, s_flush, s_req, s_acc, s_fire, s_err;
    logic [63:0] s_pc, s_addr, s_ifpc;
    logic [31:0] s_inst;

    task automatic drive();
        flush = 1'b0;
        if (rst) begin
            outstanding = 0;
            bus.imem_rsp_valid = 1'b0;
        end else begin
            if (s_fire) begin
                bus.imem_rsp_valid = 1'b0;
                outstanding = 0;
            end
            if (s_acc) begin
                outstanding = 1;
                mem_addr = s_addr;
                mem_cnt = rand_mode ? int'($urandom_range(0, 3)) : rsp_delay;
            end
            if (outstanding && !bus.imem_rsp_valid) begin
                if (mem_cnt == 0) begin
                    bus.imem_rsp_valid = 1'b1;
                    bus.imem_rsp_data  = mem_line(mem_addr);
                    bus.imem_rsp_err   = mem_fault(mem_addr);
                end else begin
                    mem_cnt--;
                end
            end else if (!outstanding && rand_mode && $urandom_range(0, 7) == 0) begin
                bus.imem_rsp_valid = 1'b1;
                bus.imem_rsp_data  = {$urandom, $urandom};
                bus.imem_rsp_err   = 1'($urandom);
            end
        end
        if (s_hs) pc = pc + 64'd4;
        if (rand_mode) begin
            if ($urandom_range(0, 15) == 0) begin
                flush = 1'b1;
                pc = 64'h8000_0000 + 64'($urandom_range(0, 1023)) * 64'd4
                   + (($urandom_range(0, 7) == 0) ? 64'd2 : 64'd0);
            end
            bus.id_ready = ($urandom_range(0, 99) < 70);
        end
        bus.imem_req_ready = (stall_left > 0) ? 1'b0
                           : (rand_mode ? ($urandom_range(0, 99) < 60) : 1'b1);
    endtask

    // One clock: compare just after the negedge, then advance and drive after the posedge.
    task automatic cycle();
        #1;
        if (!rst && !s_rst) begin
            check("ready_rule", 64'(ready), 64'(bus.if_valid & bus.id_ready & ~flush));
            if (ready) begin
                check("deliv_pc", bus.if_pc, pc);
                check("deliv_inst", 64'(bus.if_inst), 64'(exp_inst(pc)));
                check("deliv_err", 64'(bus.if_err), 64'(exp_err(pc)));
            end
            if (s_valid && !s_hs && !s_flush) begin
                check("hold_valid", 64'(bus.if_valid), 64'd1);
                check("hold_pc", bus.if_pc, s_ifpc);
                check("hold_inst", 64'(bus.if_inst), 64'(s_inst));
                check("hold_err", 64'(bus.if_err), 64'(s_err));
            end
            if (s_req && !s_acc) begin
                check("req_held", 64'(bus.imem_req_valid), 64'd1);
                check("req_addr_held", bus.imem_req_addr, s_addr);
            end
            if (bus.imem_req_valid && !s_req) begin
                check("req_pc_aligned", 64'(s_pc[1:0]), 64'd0);
                check("req_addr", bus.imem_req_addr, {s_pc[63:3], 3'b000});
            end
        end
        s_rst   = rst;
        s_valid = bus.if_valid;
        s_hs    = ready;
        s_flush = flush;
        s_req   = bus.imem_req_valid;
        s_acc   = bus.imem_req_valid & bus.imem_req_ready;
        s_addr  = bus.imem_req_addr;
        s_pc    = pc;
        s_ifpc  = bus.if_pc;
        s_inst  = bus.if_inst;
        s_err   = bus.if_err;
        s_fire  = bus.imem_rsp_valid;
        if (s_req && !bus.imem_req_ready && stall_left > 0) stall_left--;
        if (ready && !rst) hs_count++;
        @(posedge clk);
        #1;
        drive();
        @(negedge clk);
    endtask

    task automatic wait_valid(input string name);
        for (int i = 0; i < 40 && !bus.if_valid; i++) cycle();
        check(name, 64'(bus.if_valid), 64'd1);
    endtask

    int          hs0, req_cycles;
    bit          saw_valid, saw_req;
    logic [31:0] held_inst;
`ifdef YSYX_22050550_IFU_PERF_EN
    logic [63:0] stall0;
`endif

    initial begin
        rst = 1'b1;
        pc = 64'h8000_0000;
        flush = 1'b0;
        bus.id_ready = 1'b1;
        bus.imem_req_ready = 1'b1;
        bus.imem_rsp_valid = 1'b0;
        bus.imem_rsp_data = '0;
        bus.imem_rsp_err = 1'b0;
        @(negedge clk);
        cycle();
        cycle();
        check("rst_if_valid", 64'(bus.if_valid), 64'd0);
        check("rst_req_valid", 64'(bus.imem_req_valid), 64'd0);
        check("rst_ready", 64'(ready), 64'd0);
        check("rst_inst", 64'(bus.if_inst), 64'h13);
        check("rst_err", 64'(bus.if_err), 64'd0);

        // 1: aligned fetch, zero-wait memory, valid three cycles after IDLE
        rst = 1'b0;
        cycle();
        check("t1_req_valid", 64'(bus.imem_req_valid), 64'd1);
        check("t1_req_addr", bus.imem_req_addr, 64'h8000_0000);
        cycle();
        check("t1_wait_no_valid", 64'(bus.if_valid), 64'd0);
        cycle();
        check("t1_valid", 64'(bus.if_valid), 64'd1);
        check("t1_inst", 64'(bus.if_inst), 64'h0000_0013);
        check("t1_pc", bus.if_pc, 64'h8000_0000);
        check("t1_ready", 64'(ready), 64'd1);
        cycle();
        check("t1_ready_pulses", 64'(hs_count), 64'd1);

        // 2: upper word of the same line
        cycle();
        check("t2_req_addr", bus.imem_req_addr, 64'h8000_0000);
        cycle();
        cycle();
        check("t2_inst", 64'(bus.if_inst), 64'h0010_0093);
        check("t2_pc", bus.if_pc, 64'h8000_0004);

        // 3: flush while waiting on a slow response
        rsp_delay = 2;
        cycle();
        cycle();
        cycle();
        check("t3_in_wait", 64'(bus.imem_req_valid | bus.if_valid), 64'd0);
        flush = 1'b1;
        pc = 64'h8000_0100;
        hs0 = hs_count;
        saw_valid = 0;
        for (int i = 0; i < 12 && !bus.imem_req_valid; i++) begin
            cycle();
            saw_valid |= bus.if_valid;
        end
        rsp_delay = 0;
        check("t3_req_valid", 64'(bus.imem_req_valid), 64'd1);
        check("t3_no_valid", 64'(saw_valid), 64'd0);
        check("t3_no_ready", 64'(hs_count - hs0), 64'd0);
        check("t3_req_addr", bus.imem_req_addr, 64'h8000_0100);

        // 4: ID stalls for five cycles, then a flush while holding
        bus.id_ready = 1'b0;
        wait_valid("t4_valid");
        check("t4_pc", bus.if_pc, 64'h8000_0100);
        held_inst = bus.if_inst;
        for (int i = 0; i < 5; i++) begin
            cycle();
            check("t4_stable_valid", 64'(bus.if_valid), 64'd1);
            check("t4_stable_pc", bus.if_pc, 64'h8000_0100);
            check("t4_stable_inst", 64'(bus.if_inst), 64'(held_inst));
        end
        flush = 1'b1;
        pc = 64'h8000_0002;
        bus.id_ready = 1'b1;
        #1;
        check("t4_flush_ready", 64'(ready), 64'd0);
        cycle();
        check("t4_valid_drop", 64'(bus.if_valid), 64'd0);

        // 5: misaligned PC and a memory access fault
        bus.id_ready = 1'b0;
        saw_req = bus.imem_req_valid;
        cycle();
        saw_req |= bus.imem_req_valid;
        check("t5_no_req", 64'(saw_req), 64'd0);
        check("t5_valid", 64'(bus.if_valid), 64'd1);
        check("t5_err", 64'(bus.if_err), 64'd1);
        check("t5_inst", 64'(bus.if_inst), 64'h0000_0013);
        check("t5_pc", bus.if_pc, 64'h8000_0002);
        flush = 1'b1;
        pc = 64'h8000_0E00;
        cycle();
        wait_valid("t5_fault_valid");
        check("t5_fault_err", 64'(bus.if_err), 64'd1);
        check("t5_fault_pc", bus.if_pc, 64'h8000_0E00);
        check("t5_fault_inst", 64'(bus.if_inst), 64'h9234_6478);

        // 6: request refused for four cycles, response one cycle late
        stall_left = 4;
        rsp_delay = 1;
`ifdef YSYX_22050550_IFU_PERF_EN
        stall0 = perf_stall;
`endif
        flush = 1'b1;
        pc = 64'h8000_0300;
        cycle();
        req_cycles = 0;
        for (int i = 0; i < 20 && !bus.if_valid; i++) begin
            if (bus.imem_req_valid) begin
                req_cycles++;
                check("t6_addr_stable", bus.imem_req_addr, 64'h8000_0300);
            end
            cycle();
        end
        check("t6_valid", 64'(bus.if_valid), 64'd1);
        check("t6_req_cycles", 64'(req_cycles), 64'd5);
        check("t6_inst", 64'(bus.if_inst), 64'h9234_5978);
`ifdef YSYX_22050550_IFU_PERF_EN
        check("t6_perf_stall", perf_stall - stall0, 64'd7);
`endif
        rsp_delay = 0;

        // Randomized traffic against the model
        hs0 = hs_count;
        rand_mode = 1;
        repeat (4000) cycle();
        rand_mode = 0;
        stall_left = 0;
        bus.id_ready = 1'b1;
        repeat (20) cycle();
        check("rand_progress", 64'(hs_count - hs0 > 100), 64'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
